// File: rtl/dm_load_unit_pkg.sv
// Shared definitions for the data-memory load/store paths.
//   - Load-select encodings (m_lsel) consumed by the load unit.
//   - Store-select encodings consumed by the store-merge path, kept here so
//     both sides of the data memory share one definition.
//   - Exception code for a bad load address and the default memory depth.
//   - The WB-stage register layout.
package dm_load_unit_pkg;

  // Default number of 32-bit words in data memory.
  localparam int unsigned DM_WORDS_DEFAULT = 12288;

  // Exception code reported for a bad load address.
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // Load type. Encodings 101..111 are reserved and behave as a non-load.
  typedef enum logic [2:0] {
    LSEL_LW  = 3'b000,
    LSEL_LB  = 3'b001,
    LSEL_LBU = 3'b010,
    LSEL_LH  = 3'b011,
    LSEL_LHU = 3'b100
  } lsel_e;

  // Store type used by the store-merge path.
  typedef enum logic [1:0] {
    SSEL_SW = 2'b00,
    SSEL_SB = 2'b01,
    SSEL_SH = 2'b10
  } ssel_e;

  // Contents of the WB-stage register.
  typedef struct packed {
    logic        valid;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
    logic        exc;
    logic [4:0]  exc_code;
    logic [31:0] badvaddr;
  } wb_t;

endpackage

// File: rtl/dm_load_unit_load_extend.sv
// load_extend: combinational byte/halfword/word extraction and extension.
// Ports:
//   raw_i        in  32  raw word read from data memory
//   off_i        in  2   byte offset within the word (address bits [1:0])
//   lsel_i       in  3   load type (lsel_e encoding)
//   data_o       out 32  extracted and sign/zero-extended value
//   misaligned_o out 1   access is not naturally aligned for its size
//   legal_o      out 1   lsel_i is a defined load encoding
module load_extend
  import dm_load_unit_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  lsel_i,
  output logic [31:0] data_o,
  output logic        misaligned_o,
  output logic        legal_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw_i[7:0];
    case (off_i)
      2'b00: byte_sel = raw_i[7:0];
      2'b01: byte_sel = raw_i[15:8];
      2'b10: byte_sel = raw_i[23:16];
      2'b11: byte_sel = raw_i[31:24];
      default: byte_sel = raw_i[7:0];
    endcase
  end

  assign half_sel = off_i[1] ? raw_i[31:16] : raw_i[15:0];

  always_comb begin
    data_o       = 32'h0;
    misaligned_o = 1'b0;
    legal_o      = 1'b1;
    case (lsel_i)
      LSEL_LW: begin
        data_o       = raw_i;
        misaligned_o = (off_i != 2'b00);
      end
      LSEL_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LSEL_LBU: data_o = {24'h0, byte_sel};
      LSEL_LH: begin
        data_o       = {{16{half_sel[15]}}, half_sel};
        misaligned_o = off_i[0];
      end
      LSEL_LHU: begin
        data_o       = {16'h0, half_sel};
        misaligned_o = off_i[0];
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dm_load_unit.sv
// dm_load_unit: MEM->WB load path of the data memory.
// Drives the word-aligned read address, extracts and extends the addressed
// byte/halfword/word from the returned word, checks alignment and range, and
// registers the result into the WB stage with stall and flush.
// Ports:
//   clk, reset (sync, active-high)
//   m_valid, m_load, m_lsel[2:0], m_addr[31:0], m_pc[31:0], m_rd[4:0]  MEM stage
//   stall, flush                                                      WB control
//   dm_addr[31:0] out (combinational), dm_rdata[31:0] in              data memory
//   w_valid, w_we, w_rd, w_data, w_pc, w_exc, w_exc_code, w_badvaddr  WB stage
module dm_load_unit
  import dm_load_unit_pkg::*;
#(
  parameter int unsigned DM_WORDS = DM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic        m_load,
  input  logic [2:0]  m_lsel,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_pc,
  input  logic [4:0]  m_rd,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] dm_addr,
  input  logic [31:0] dm_rdata,
  output logic        w_valid,
  output logic        w_we,
  output logic [4:0]  w_rd,
  output logic [31:0] w_data,
  output logic [31:0] w_pc,
  output logic        w_exc,
  output logic [4:0]  w_exc_code,
  output logic [31:0] w_badvaddr
);

  // One extra bit so the byte limit cannot wrap for large memories.
  localparam logic [32:0] DM_BYTES = 33'(DM_WORDS) << 2;

  logic [31:0] ext_data;
  logic        misaligned;
  logic        lsel_legal;
  logic        capture;
  logic        out_of_range;
  logic        exc;
  wb_t         wb_d;
  wb_t         wb_q;

  // Read address ignores stall/flush: memory is always presented the MEM address.
  assign dm_addr = {m_addr[31:2], 2'b00};

  load_extend u_load_extend (
    .raw_i        (dm_rdata),
    .off_i        (m_addr[1:0]),
    .lsel_i       (m_lsel),
    .data_o       (ext_data),
    .misaligned_o (misaligned),
    .legal_o      (lsel_legal)
  );

  assign capture      = m_valid & m_load & lsel_legal;
  assign out_of_range = ({1'b0, m_addr} >= DM_BYTES);
  assign exc          = misaligned | out_of_range;

  // Anything that is not a captured load enters WB as an all-zero bubble.
  // A faulting load carries no data and never writes the register file.
  always_comb begin
    wb_d = '0;
    if (capture) begin
      wb_d.valid = 1'b1;
      wb_d.rd    = m_rd;
      wb_d.pc    = m_pc;
      if (exc) begin
        wb_d.exc      = 1'b1;
        wb_d.exc_code = EXC_ADEL;
        wb_d.badvaddr = m_addr;
      end else begin
        wb_d.data = ext_data;
        wb_d.we   = (m_rd != 5'd0);
      end
    end
  end

  // Priority: reset, flush (clears everything), stall (hold), capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q <= '0;
    end else if (flush) begin
      wb_q <= '0;
    end else if (!stall) begin
      wb_q <= wb_d;
    end
  end

  assign w_valid    = wb_q.valid;
  assign w_we       = wb_q.we;
  assign w_rd       = wb_q.rd;
  assign w_data     = wb_q.data;
  assign w_pc       = wb_q.pc;
  assign w_exc      = wb_q.exc;
  assign w_exc_code = wb_q.exc_code;
  assign w_badvaddr = wb_q.badvaddr;

endmodule

// File: tb/tb_dm_load_unit.sv
// Testbench for dm_load_unit: directed loads against a small data memory
// model with a store port, expected WB contents queued per cycle and checked
// by an independent monitor on the falling edge.
module tb_dm_load_unit;
  import dm_load_unit_pkg::*;

  localparam int EW = 109;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        m_valid, m_load;
  logic [2:0]  m_lsel;
  logic [31:0] m_addr, m_pc;
  logic [4:0]  m_rd;
  logic        stall, flush;
  logic [31:0] dm_addr, dm_rdata;
  logic        w_valid, w_we, w_exc;
  logic [4:0]  w_rd, w_exc_code;
  logic [31:0] w_data, w_pc, w_badvaddr;

  dm_load_unit dut (
    .clk        (clk),
    .reset      (reset),
    .m_valid    (m_valid),
    .m_load     (m_load),
    .m_lsel     (m_lsel),
    .m_addr     (m_addr),
    .m_pc       (m_pc),
    .m_rd       (m_rd),
    .stall      (stall),
    .flush      (flush),
    .dm_addr    (dm_addr),
    .dm_rdata   (dm_rdata),
    .w_valid    (w_valid),
    .w_we       (w_we),
    .w_rd       (w_rd),
    .w_data     (w_data),
    .w_pc       (w_pc),
    .w_exc      (w_exc),
    .w_exc_code (w_exc_code),
    .w_badvaddr (w_badvaddr)
  );

  // ---------------- data memory model ----------------
  logic [31:0] mem [0:12287];
  logic        st_en;
  logic [31:0] st_addr, st_data;

  always @(posedge clk) begin
    if (st_en) mem[st_addr[15:2]] <= st_data;
  end

  assign dm_rdata = (dm_addr[31:2] < 30'd12288) ? mem[dm_addr[15:2]] : 32'h0;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  function automatic logic [EW-1:0] mk_exp(input logic v, we, input logic [4:0] rd,
                                            input logic [31:0] data, pc,
                                            input logic ex, input logic [4:0] code,
                                            input logic [31:0] badv);
    return {v, we, rd, data, pc, ex, code, badv};
  endfunction

  function automatic logic [EW-1:0] ok(input logic [4:0] rd, input logic [31:0] data, pc);
    return mk_exp(1'b1, rd != 5'd0, rd, data, pc, 1'b0, 5'd0, 32'h0);
  endfunction

  function automatic logic [EW-1:0] ex(input logic [4:0] rd, input logic [31:0] pc, addr);
    return mk_exp(1'b1, 1'b0, rd, 32'h0, pc, 1'b1, 5'd4, addr);
  endfunction

  localparam logic [EW-1:0] ZERO = '0;

  // Monitor: WB outputs are compared once per cycle on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {w_valid, w_we, w_rd, w_data, w_pc, w_exc, w_exc_code, w_badvaddr};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, ld, input logic [2:0] ls,
                      input logic [31:0] a, pc, input logic [4:0] rd,
                      input logic stl, fl, rst,
                      input logic [EW-1:0] e, input string nm);
    m_valid = v; m_load = ld; m_lsel = ls; m_addr = a; m_pc = pc; m_rd = rd;
    stall = stl; flush = fl; reset = rst; st_en = 1'b0;
    #1;
    n_checks++;
    if (dm_addr === {a[31:2], 2'b00}) n_pass++;
    else $display("FAIL dm_addr_%s: got %h expected %h", nm, dm_addr, {a[31:2], 2'b00});
    @(posedge clk);
    exp_q.push_back(e);
    name_q.push_back(nm);
    #1;
  endtask

  task automatic load(input logic [2:0] ls, input logic [31:0] a, pc,
                      input logic [4:0] rd, input logic [EW-1:0] e, input string nm);
    step(1'b1, 1'b1, ls, a, pc, rd, 1'b0, 1'b0, 1'b0, e, nm);
  endtask

  task automatic store(input logic [31:0] a, d);
    m_valid = 1'b0; m_load = 1'b0; m_lsel = 3'b000; m_addr = 32'h0;
    m_pc = 32'h0; m_rd = 5'd0; stall = 1'b0; flush = 1'b0; reset = 1'b0;
    st_en = 1'b1; st_addr = a; st_data = d;
    @(posedge clk);
    exp_q.push_back(ZERO);
    name_q.push_back("store_bubble");
    #1;
    st_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 12288; i++) mem[i] = 32'h0;
    mem[14'h400]  = 32'h80FF7F01;
    mem[14'h2FFF] = 32'h12345678;
    st_en = 1'b0; st_addr = 32'h0; st_data = 32'h0;
    m_valid = 1'b0; m_load = 1'b0; m_lsel = 3'b000; m_addr = 32'h0;
    m_pc = 32'h0; m_rd = 5'd0; stall = 1'b0; flush = 1'b0; reset = 1'b1;
    @(posedge clk); #1;

    step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, ZERO, "reset_state");

    // Extraction and extension, back to back.
    load(LSEL_LB,  32'h1003, 32'h100, 5'd5, ok(5'd5, 32'hFFFFFF80, 32'h100), "lb_sext");
    load(LSEL_LBU, 32'h1001, 32'h104, 5'd6, ok(5'd6, 32'h0000007F, 32'h104), "lbu");
    load(LSEL_LHU, 32'h1002, 32'h108, 5'd7, ok(5'd7, 32'h000080FF, 32'h108), "lhu");
    load(LSEL_LH,  32'h1002, 32'h10C, 5'd8, ok(5'd8, 32'hFFFF80FF, 32'h10C), "lh_sext");
    load(LSEL_LB,  32'h1000, 32'h110, 5'd9, ok(5'd9, 32'h00000001, 32'h110), "lb_pos");
    load(LSEL_LH,  32'h1000, 32'h114, 5'd9, ok(5'd9, 32'h00007F01, 32'h114), "lh_pos");
    load(LSEL_LBU, 32'h1002, 32'h118, 5'd9, ok(5'd9, 32'h000000FF, 32'h118), "lbu_b2");
    load(LSEL_LW,  32'h1000, 32'h11C, 5'd9, ok(5'd9, 32'h80FF7F01, 32'h11C), "lw");

    // Alignment and range exceptions.
    load(LSEL_LW,  32'h1002, 32'h120, 5'd4, ex(5'd4, 32'h120, 32'h1002), "lw_misaligned");
    load(LSEL_LH,  32'h1001, 32'h124, 5'd4, ex(5'd4, 32'h124, 32'h1001), "lh_misaligned");
    load(LSEL_LHU, 32'h1003, 32'h128, 5'd4, ex(5'd4, 32'h128, 32'h1003), "lhu_misaligned");
    load(LSEL_LW,  32'hC000, 32'h12C, 5'd4, ex(5'd4, 32'h12C, 32'hC000), "lw_out_of_range");
    load(LSEL_LB,  32'hC001, 32'h130, 5'd4, ex(5'd4, 32'h130, 32'hC001), "lb_out_of_range");
    load(LSEL_LW,  32'hBFFC, 32'h134, 5'd4, ok(5'd4, 32'h12345678, 32'h134), "lw_last_word");

    // Non-loads: reserved encodings, invalid slot, non-load instruction.
    load(3'b101, 32'h1000, 32'h138, 5'd3, ZERO, "reserved_101");
    load(3'b111, 32'h1002, 32'h13C, 5'd3, ZERO, "reserved_111");
    step(1'b0, 1'b1, LSEL_LW, 32'h1000, 32'h140, 5'd3, 1'b0, 1'b0, 1'b0, ZERO, "not_valid");
    step(1'b1, 1'b0, LSEL_LW, 32'h1000, 32'h144, 5'd3, 1'b0, 1'b0, 1'b0, ZERO, "not_load");

    // Stall holds A while B waits; stall+flush clears; flush alone clears.
    load(LSEL_LW, 32'h1000, 32'h200, 5'd10, ok(5'd10, 32'h80FF7F01, 32'h200), "stall_a");
    step(1'b1, 1'b1, LSEL_LBU, 32'h1001, 32'h204, 5'd11, 1'b1, 1'b0, 1'b0,
         ok(5'd10, 32'h80FF7F01, 32'h200), "stall_hold1");
    step(1'b1, 1'b1, LSEL_LBU, 32'h1001, 32'h204, 5'd11, 1'b1, 1'b0, 1'b0,
         ok(5'd10, 32'h80FF7F01, 32'h200), "stall_hold2");
    step(1'b1, 1'b1, LSEL_LBU, 32'h1001, 32'h204, 5'd11, 1'b0, 1'b0, 1'b0,
         ok(5'd11, 32'h0000007F, 32'h204), "stall_release");
    step(1'b1, 1'b1, LSEL_LBU, 32'h1001, 32'h208, 5'd12, 1'b1, 1'b1, 1'b0, ZERO, "stall_and_flush");
    load(LSEL_LW, 32'h1002, 32'h20C, 5'd12, ex(5'd12, 32'h20C, 32'h1002), "exc_before_flush");
    step(1'b1, 1'b1, LSEL_LW, 32'h1000, 32'h210, 5'd12, 1'b0, 1'b1, 1'b0, ZERO, "flush_only");

    // Destination zero: valid but no write.
    load(LSEL_LW, 32'h1000, 32'h300, 5'd0, ok(5'd0, 32'h80FF7F01, 32'h300), "rd_zero");

    // Store in cycle N, load of the same address in cycle N+1.
    store(32'h2000, 32'hA5A55A5A);
    load(LSEL_LW, 32'h2000, 32'h400, 5'd13, ok(5'd13, 32'hA5A55A5A, 32'h400), "store_then_lw");
    load(LSEL_LB, 32'h2003, 32'h404, 5'd14, ok(5'd14, 32'hFFFFFFA5, 32'h404), "store_then_lb");

    // Reset with a valid WB entry discards it.
    load(LSEL_LW, 32'h1000, 32'h500, 5'd3, ok(5'd3, 32'h80FF7F01, 32'h500), "pre_reset");
    step(1'b1, 1'b1, LSEL_LW, 32'h1000, 32'h504, 5'd3, 1'b0, 1'b0, 1'b1, ZERO, "reset_mid");
    load(LSEL_LHU, 32'h1000, 32'h508, 5'd2, ok(5'd2, 32'h00007F01, 32'h508), "after_reset");

    step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, ZERO, "idle");

    // Drain: bounded wait for the monitor to consume all expectations.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dm_load_unit.md
# dm_load_unit

Load-side counterpart of the data memory's store-merge path. It sits between the MEM and WB pipeline stages, drives the word-aligned read address to the data memory, and extracts plus sign/zero-extends the addressed byte, halfword or word from the raw 32-bit read word. It also checks alignment and range, and registers the result, destination register and exception information into the WB stage with stall and flush support.

## Interface
- `DM_WORDS`, 12288: number of 32-bit words in data memory; the valid byte range is `0 .. DM_WORDS*4-1`.
- `EXC_ADEL`, 5'd4: exception code reported for a bad load address.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `m_valid` in 1: MEM stage holds a real instruction.
- `m_load` in 1: instruction is a load.
- `m_lsel` in 3: load type. 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; 101–111 reserved.
- `m_addr` in 32: effective byte address.
- `m_pc` in 32: instruction PC.
- `m_rd` in 5: destination GPR.
- `stall` in 1: hold the WB register.
- `flush` in 1: kill the instruction entering WB.
- `dm_addr` out 32: `{m_addr[31:2],2'b00}` to data memory; combinational.
- `dm_rdata` in 32: raw word from data memory; combinational in the same cycle as `dm_addr`.
- `w_valid` out 1: WB stage holds an instruction from this unit.
- `w_we` out 1: GPR write enable.
- `w_rd` out 5: destination GPR.
- `w_data` out 32: extended load data.
- `w_pc` out 32: instruction PC.
- `w_exc` out 1: load address exception.
- `w_exc_code` out 5: `EXC_ADEL` when `w_exc` is 1, else 0.
- `w_badvaddr` out 32: faulting byte address when `w_exc` is 1, else 0.

## Operation
- Capture condition: an instruction is captured when `m_valid & m_load` and the `m_lsel` encoding is legal. Reserved encodings act as a non-load: valid=0, no exception.
- Extraction from `off = m_addr[1:0]`:
  - LW returns the whole word.
  - LB/LBU return byte `off`: 00→[7:0], 01→[15:8], 10→[23:16], 11→[31:24].
  - LH/LHU return `off[1]` ? [31:16] : [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Exception conditions:
  - LW with `off != 0`.
  - LH/LHU with `off[0] = 1`.
  - `m_addr >= DM_WORDS*4`.
- On an exception: `w_exc=1`, `w_exc_code=EXC_ADEL`, `w_badvaddr=m_addr`, `w_we=0`, `w_data=0`. Exception takes precedence over data.
- Write enable: `w_we = valid & ~exc & (m_rd != 0)`.
- Register update priority, highest first:
  - reset: all outputs 0.
  - flush: `w_valid`, `w_we`, `w_exc` and `w_exc_code` all 0; the other fields are don't-care but are driven to 0.
  - stall: hold every output.
  - otherwise: capture the new values.
- Reset mid-operation discards the WB contents immediately.
- `dm_addr` is unaffected by stall and flush.

## Timing
- Latency is 1 cycle: data is valid in WB the cycle after the MEM cycle in which `dm_rdata` is sampled.
- Extraction and extension happen before the register, so `w_*` are pure flop outputs.
- `dm_addr` is combinational from `m_addr`.
- The data memory writes on the same edge. A store in cycle N followed by a load from the same address in cycle N+1 sees the new data; the bench checks this.
- Reset values: all `w_*` outputs are 0.
- `stall` and `flush` asserted together: flush wins.
- Back-to-back loads: one accepted per cycle with no bubbles while `stall=0`.

## Structure
- Shared package holds:
  - `LSEL_LW`, `LSEL_LB`, `LSEL_LBU`, `LSEL_LH`, `LSEL_LHU`.
  - `EXC_ADEL`.
  - The store-select encodings used by the store path, so both sides share one definition.
- Sub-module `load_extend`: combinational (raw word, `off`, `lsel`) → (data, misaligned).
- The top level holds the range check, the WB register and the stall/flush logic.

## Test plan
- **LB sign-extend:** `dm_rdata=32'h80FF7F01`, `m_addr=0x1003`, LB, rd=5 → next cycle `w_data=32'hFFFFFF80`, `w_we=1`, `w_rd=5`.
- **LBU and LHU:** `dm_rdata=32'h80FF7F01`, `m_addr=0x1001` LBU → `32'h0000007F`; `m_addr=0x1002` LHU → `32'h000080FF`.
- **Misaligned LW:** LW at `0x1002` → `w_exc=1`, `w_exc_code=4`, `w_badvaddr=0x1002`, `w_we=0`, `w_data=0`.
- **Out-of-range load:** LW at `0x0000C000` → exception with `w_badvaddr=0xC000`; LW at `0xBFFC` → no exception.
- **Stall and flush:** load A, then `stall=1` for 2 cycles while load B is presented → `w_*` hold A. Then `stall=1` and `flush=1` together → `w_valid=0`.
- **Destination zero and reset:** load to rd=0 → `w_valid=1`, `w_we=0`. `reset=1` with a valid WB entry → all outputs 0 after the edge.
